// File: rtl/vga_pattern_src.sv
// VGA test-pattern pixel source: bars, checker, bouncing box and grey ramp, with a debounced mode key.
// Optional auto mode cycling is compiled in with VGA_PAT_AUTO_CYCLE_EN.
module vga_pattern_src #(
  parameter int DEBOUNCE_CYC = 500000,
  parameter int BOX_STEP     = 2,
  parameter int AUTO_FRAMES  = 120
) (
  input  logic        Clk25M,
  input  logic        Rst_n,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        vga_blk,
  input  logic        key_n,
  output logic [23:0] data_out,
  output logic [1:0]  mode
);

  localparam int              DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYC);
  localparam logic [DB_W-1:0] DB_PRE = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [10:0]     STEP   = 11'(BOX_STEP);

  logic            key_s1, key_s2;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  logic            pend;
  logic            frame_tick;
  logic [9:0]      box_x, box_y;
  logic            dir_x, dir_y;
  logic            in_box;

  // Returns {dir, pos} after one frame of motion, pinning to the wall on a bounce.
  function automatic logic [10:0] next_axis(input logic [9:0] pos, input logic dir,
                                            input logic [9:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (dir) begin
      if (p + STEP >= {1'b0, lim}) return {1'b0, lim};
      else                         return {1'b1, 10'(p + STEP)};
    end else begin
      if (p <= STEP) return {1'b1, 10'd0};
      else           return {1'b0, 10'(p - STEP)};
    end
  endfunction

  function automatic logic [23:0] bar_colour(input logic [9:0] h);
    if      (h < 10'd80)  return 24'hFFFFFF;
    else if (h < 10'd160) return 24'hFFFF00;
    else if (h < 10'd240) return 24'h00FFFF;
    else if (h < 10'd320) return 24'h00FF00;
    else if (h < 10'd400) return 24'hFF00FF;
    else if (h < 10'd480) return 24'hFF0000;
    else if (h < 10'd560) return 24'h0000FF;
    else                  return 24'h000000;
  endfunction

  // Key synchroniser and debounce; press fires once as the counter reaches DEBOUNCE_CYC.
  always_ff @(posedge Clk25M) begin
    if (!Rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      db_cnt <= '0;
      press  <= 1'b0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      press  <= !key_s2 && (db_cnt == DB_PRE);
      if (key_s2)                db_cnt <= '0;
      else if (db_cnt != DB_MAX) db_cnt <= db_cnt + 1'b1;
    end
  end

`ifdef VGA_PAT_AUTO_CYCLE_EN
  localparam int              FC_W   = $clog2(AUTO_FRAMES + 1);
  localparam logic [FC_W-1:0] F_LAST = FC_W'(AUTO_FRAMES - 1);
  logic [FC_W-1:0] fcnt;
`endif

  // Frame-rate state: everything below moves only on the tick after the last active pixel.
  always_ff @(posedge Clk25M) begin
    if (!Rst_n) begin
      frame_tick <= 1'b0;
      mode       <= 2'd0;
      pend       <= 1'b0;
      box_x      <= '0;
      box_y      <= '0;
      dir_x      <= 1'b1;
      dir_y      <= 1'b1;
`ifdef VGA_PAT_AUTO_CYCLE_EN
      fcnt       <= '0;
`endif
    end else begin
      frame_tick <= vga_blk && (hcount == 10'd639) && (vcount == 10'd479);
      if (frame_tick) begin
        {dir_x, box_x} <= next_axis(box_x, dir_x, 10'd576);
        {dir_y, box_y} <= next_axis(box_y, dir_y, 10'd416);
      end
`ifdef VGA_PAT_AUTO_CYCLE_EN
      if (frame_tick) begin
        pend <= 1'b0;
        if (pend || press || fcnt == F_LAST) begin
          mode <= mode + 2'd1;
          fcnt <= '0;
        end else begin
          fcnt <= fcnt + 1'b1;
        end
      end else if (press) begin
        pend <= 1'b1;
      end
`else
      if (frame_tick && (pend || press)) begin
        mode <= mode + 2'd1;
        pend <= 1'b0;
      end else if (press) begin
        pend <= 1'b1;
      end
`endif
    end
  end

  // Zero-latency pixel function
  always_comb begin
    data_out = 24'h000000;
    in_box   = ({1'b0, hcount} >= {1'b0, box_x}) && ({1'b0, hcount} < {1'b0, box_x} + 11'd64) &&
               ({1'b0, vcount} >= {1'b0, box_y}) && ({1'b0, vcount} < {1'b0, box_y} + 11'd64);
    if (vga_blk) begin
      case (mode)
        2'd0:    data_out = bar_colour(hcount);
        2'd1:    data_out = (hcount[5] ^ vcount[5]) ? 24'hFFFFFF : 24'h000000;
        2'd2:    data_out = in_box ? 24'hFF0000 : 24'h000020;
        default: data_out = {hcount[9:2], hcount[9:2], hcount[9:2]};
      endcase
    end
  end

endmodule

// File: tb/tb_vga_pattern_src.sv
// Directed bench for vga_pattern_src with DEBOUNCE_CYC=16, BOX_STEP=2, AUTO_FRAMES=4.
module tb_vga_pattern_src;
  localparam int DB = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  hcount, vcount;
  logic        vga_blk, key_n;
  logic [23:0] data_out;
  logic [1:0]  mode;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        blk;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [23:0] exp;
  } vec_t;
  vec_t vq[$];

  vga_pattern_src #(.DEBOUNCE_CYC(DB), .BOX_STEP(2), .AUTO_FRAMES(4)) dut (
    .Clk25M(clk), .Rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .vga_blk(vga_blk), .key_n(key_n), .data_out(data_out), .mode(mode));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic blank();
    vga_blk = 1'b0; hcount = '0; vcount = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; key_n = 1'b1; blank();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One frame boundary: last active pixel, then blanking until the update is visible.
  task automatic tick();
    @(negedge clk);
    vga_blk = 1'b1; hcount = 10'd639; vcount = 10'd479;
    @(negedge clk);
    blank();
    @(negedge clk);
  endtask

  task automatic press_key();
    @(negedge clk);
    key_n = 1'b0;
    repeat (DB + 5) @(negedge clk);
    key_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic run_vecs(input string tag);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      vga_blk = vq[i].blk; hcount = vq[i].h; vcount = vq[i].v;
      #2;
      check($sformatf("%s[%0d]", tag, i), {8'h0, data_out}, {8'h0, vq[i].exp});
    end
    vq.delete();
    @(negedge clk);
    blank();
  endtask

  initial begin
    rst_n = 1'b0; key_n = 1'b1; blank();
    do_reset();
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_pix", {8'h0, data_out}, 32'h0);
    check("reset_box", {21'h0, dut.dir_x, dut.box_x}, {21'h0, 1'b1, 10'd0});

`ifdef VGA_PAT_AUTO_CYCLE_EN
    for (int f = 1; f <= 16; f++) begin
      tick();
      check($sformatf("auto_f%0d", f), 32'(mode), 32'((f / 4) % 4));
    end
    do_reset();
    tick(); tick();
    press_key();
    check("auto_pend_mode", 32'(mode), 32'd0);
    tick();
    check("auto_press_adv", 32'(mode), 32'd1);
    tick(); tick(); tick();
    check("auto_restart_hold", 32'(mode), 32'd1);
    tick();
    check("auto_restart_wrap", 32'(mode), 32'd2);
`else
    // Colour bars, including every bar edge and the blanked case
    vq.push_back('{1'b1, 10'd0,   10'd0,   24'hFFFFFF});
    vq.push_back('{1'b1, 10'd85,  10'd10,  24'hFFFF00});
    vq.push_back('{1'b1, 10'd639, 10'd479, 24'h000000});
    vq.push_back('{1'b0, 10'd300, 10'd200, 24'h000000});
    vq.push_back('{1'b1, 10'd79,  10'd0,   24'hFFFFFF});
    vq.push_back('{1'b1, 10'd160, 10'd0,   24'h00FFFF});
    vq.push_back('{1'b1, 10'd240, 10'd0,   24'h00FF00});
    vq.push_back('{1'b1, 10'd320, 10'd0,   24'hFF00FF});
    vq.push_back('{1'b1, 10'd400, 10'd0,   24'hFF0000});
    vq.push_back('{1'b1, 10'd480, 10'd0,   24'h0000FF});
    vq.push_back('{1'b1, 10'd560, 10'd0,   24'h000000});
    run_vecs("bars");

    // Key to checker: press latency, pending until the frame tick, two-cycle update
    do_reset();
    begin
      int k;
      @(negedge clk);
      key_n = 1'b0;
      k = 0;
      while (k <= 40) begin
        @(negedge clk);
        k++;
        if (dut.press) break;
      end
      check("press_latency", 32'(k), 32'(DB + 2));
      repeat (5) @(negedge clk);
      key_n = 1'b1;
      repeat (3) @(negedge clk);
    end
    check("pend_set", 32'(dut.pend), 32'd1);
    check("mode_waits", 32'(mode), 32'd0);
    @(negedge clk);
    vga_blk = 1'b1; hcount = 10'd639; vcount = 10'd479;
    @(negedge clk);
    blank();
    check("mode_tick_plus1", 32'(mode), 32'd0);
    @(negedge clk);
    check("mode_tick_plus2", 32'(mode), 32'd1);
    check("pend_clear", 32'(dut.pend), 32'd0);
    vq.push_back('{1'b1, 10'd32, 10'd0,  24'hFFFFFF});
    vq.push_back('{1'b1, 10'd32, 10'd32, 24'h000000});
    vq.push_back('{1'b1, 10'd0,  10'd0,  24'h000000});
    vq.push_back('{1'b1, 10'd0,  10'd32, 24'hFFFFFF});
    run_vecs("checker");

    // Held key yields a single press
    @(negedge clk);
    key_n = 1'b0;
    repeat (60) @(negedge clk);
    tick();
    check("held_first", 32'(mode), 32'd2);
    tick(); tick();
    check("held_no_repeat", 32'(mode), 32'd2);
    key_n = 1'b1;
    repeat (3) @(negedge clk);

    // Glitch shorter than the debounce window
    do_reset();
    @(negedge clk);
    key_n = 1'b0;
    repeat (10) @(negedge clk);
    key_n = 1'b1;
    repeat (3) @(negedge clk);
    tick(); tick();
    check("glitch_mode", 32'(mode), 32'd0);
    check("glitch_pend", 32'(dut.pend), 32'd0);

    // Box trajectory and both bounces
    do_reset();
    tick();
    check("box_f1_x", 32'(dut.box_x), 32'd2);
    check("box_f1_y", 32'(dut.box_y), 32'd2);
    repeat (207) tick();
    check("box_f208_y", {21'h0, dut.dir_y, dut.box_y}, {21'h0, 1'b0, 10'd416});
    check("box_f208_x", {21'h0, dut.dir_x, dut.box_x}, {21'h0, 1'b1, 10'd416});
    tick();
    check("box_f209_y", 32'(dut.box_y), 32'd414);
    repeat (79) tick();
    check("box_f288_x", {21'h0, dut.dir_x, dut.box_x}, {21'h0, 1'b0, 10'd576});
    check("box_f288_y", 32'(dut.box_y), 32'd256);
    tick();
    check("box_f289_x", 32'(dut.box_x), 32'd574);

    // Box pixels: two press+tick pairs leave mode 2 with the box at (4,4)
    do_reset();
    press_key(); tick();
    press_key(); tick();
    check("box_mode", 32'(mode), 32'd2);
    vq.push_back('{1'b1, 10'd4,  10'd4,  24'hFF0000});
    vq.push_back('{1'b1, 10'd3,  10'd3,  24'h000020});
    vq.push_back('{1'b1, 10'd67, 10'd67, 24'hFF0000});
    vq.push_back('{1'b1, 10'd68, 10'd4,  24'h000020});
    vq.push_back('{1'b1, 10'd4,  10'd68, 24'h000020});
    vq.push_back('{1'b0, 10'd4,  10'd4,  24'h000000});
    run_vecs("box");

    // Grey ramp, then reset in the middle of row 200
    press_key(); tick();
    check("ramp_mode", 32'(mode), 32'd3);
    vq.push_back('{1'b1, 10'd400, 10'd0,   24'h646464});
    vq.push_back('{1'b1, 10'd0,   10'd0,   24'h000000});
    vq.push_back('{1'b1, 10'd639, 10'd100, 24'h9F9F9F});
    run_vecs("ramp");
    @(negedge clk);
    vga_blk = 1'b1; hcount = 10'd400; vcount = 10'd200;
    #2;
    check("pre_reset_pix", {8'h0, data_out}, 32'h646464);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_box", 32'(dut.box_x), 32'd0);
    check("midrst_pix", {8'h0, data_out}, 32'hFF0000);
    rst_n = 1'b1;
    blank();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
